regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file with scoreboard, built for the pipelined RISC-Duo core. It provides NRD combinational read ports and NWR synchronous write ports, with optional write-to-read bypass. A per-register busy (pending-write) bit is set at issue and cleared at writeback, so the hazard unit can stall without a separate scoreboard. Register 0 is hard-wired to zero and is never busy.

---
 rtl/regfile_mp_sb.sv | 99 +++++++++
 tb/tb_regfile_mp_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a built-in pending-write scoreboard.
// x0 is hard-wired to zero and never busy; reads are combinational, with an optional write bypass.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0][XLEN-1:0]   rd_data,
  output logic [NRD-1:0]             rd_busy,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR-1:0][AW-1:0]     wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  output logic [AW:0]                busy_cnt,
  output logic [NREGS-1:0]           busy_vec
);

  logic [XLEN-1:0]  regs_reg   [NREGS];
  logic [XLEN-1:0]  wdata_next [NREGS];
  logic [NREGS-1:0] busy_reg, busy_next;
  logic [NREGS-1:0] wr_hit, rsv_hit;
  logic [AW:0]      busy_cnt_reg, busy_cnt_next;

  // Per-register write resolution: scanning ports upward lets the highest index win.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r]     = 1'b0;
      wdata_next[r] = regs_reg[r];
      rsv_hit[r]    = (r != 0) && rsv_en && (rsv_addr == AW'(r));
      for (int p = 0; p < NWR; p++) begin
        if ((r != 0) && wr_en[p] && (wr_addr[p] == AW'(r))) begin
          wr_hit[r]     = 1'b1;
          wdata_next[r] = wr_data[p];
        end
      end
      // A reservation always beats a writeback: the newer producer owns the register.
      busy_next[r] = rsv_hit[r] | (busy_reg[r] & ~wr_hit[r]);
    end
  end

  always_comb begin
    busy_cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= wdata_next[r];
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [XLEN-1:0] data_c;
      logic            busy_c;

      always_comb begin
        data_c = regs_reg[rd_addr[gi]];
        busy_c = busy_reg[rd_addr[gi]];
        // Bypass is gated by rst_n so outputs read zero throughout reset.
        if ((BYPASS != 0) && rst_n && wr_hit[rd_addr[gi]]) begin
          data_c = wdata_next[rd_addr[gi]];
          busy_c = rsv_hit[rd_addr[gi]] ? busy_reg[rd_addr[gi]] : 1'b0;
        end
        if (rd_addr[gi] == '0) begin
          data_c = '0;
          busy_c = 1'b0;
        end
      end

      assign rd_data[gi] = data_c;
      assign rd_busy[gi] = busy_c;
    end
  endgenerate

  assign busy_vec = busy_reg;
  assign busy_cnt = busy_cnt_reg;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: one DUT with bypass and one without share the stimulus;
// a reference model predicts every cycle's outputs, and a negedge monitor compares them.
module tb_regfile_mp_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);
  localparam int NRAND = 10000;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]           rd_busy_b, rd_busy_n;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic [AW:0]              busy_cnt_b, busy_cnt_n;
  logic [NREGS-1:0]         busy_vec_b, busy_vec_n;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt_b), .busy_vec(busy_vec_b)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt_n), .busy_vec(busy_vec_n)
  );

  typedef struct packed {
    logic [NRD-1:0][XLEN-1:0] d_b;
    logic [NRD-1:0][XLEN-1:0] d_n;
    logic [NRD-1:0]           b_b;
    logic [NRD-1:0]           b_n;
    logic [AW:0]              cnt;
    logic [NREGS-1:0]         vec;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] m_data [NREGS];
  logic [NREGS-1:0] m_busy;
  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) m_data[r] = '0;
    m_busy = '0;
  endtask

  // Predict this cycle's outputs from the architectural state, queue them, then
  // advance the state across the clock edge.
  task automatic drive();
    exp_t e;
    int a;
    if (!rst_n) model_clear();
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_addr[i]);
      e.d_n[i] = m_data[a];
      e.b_n[i] = m_busy[a];
      e.d_b[i] = m_data[a];
      e.b_b[i] = m_busy[a];
      if (rst_n && a != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && int'(wr_addr[p]) == a) begin
            e.d_b[i] = wr_data[p];
            e.b_b[i] = (rsv_en && int'(rsv_addr) == a) ? m_busy[a] : 1'b0;
          end
        end
      end
    end
    e.cnt = (AW+1)'($countones(m_busy));
    e.vec = m_busy;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p] != '0) begin
          m_data[wr_addr[p]] = wr_data[p];
          m_busy[wr_addr[p]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NRD; i++) begin
          chk($sformatf("rd_data_b[%0d]", i), rd_data_b[i], e.d_b[i]);
          chk($sformatf("rd_data_n[%0d]", i), rd_data_n[i], e.d_n[i]);
          chk($sformatf("rd_busy_b[%0d]", i), XLEN'(rd_busy_b[i]), XLEN'(e.b_b[i]));
          chk($sformatf("rd_busy_n[%0d]", i), XLEN'(rd_busy_n[i]), XLEN'(e.b_n[i]));
        end
        chk("busy_cnt_b", XLEN'(busy_cnt_b), XLEN'(e.cnt));
        chk("busy_cnt_n", XLEN'(busy_cnt_n), XLEN'(e.cnt));
        chk("busy_vec_b", XLEN'(busy_vec_b), XLEN'(e.vec));
        chk("busy_vec_n", XLEN'(busy_vec_n), XLEN'(e.vec));
        $display("txn %0d rst_n=%0b rd=%h cnt=%0d vec=%h", txn, rst_n, rd_addr, e.cnt, e.vec);
        txn++;
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    idle();
    model_clear();
    @(posedge clk); #1;
    drive(); drive();

    // Write presented during reset must neither bypass nor land.
    wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 64'h1234; rd_addr = {4'd5, 4'd5, 4'd5};
    #2 chk("rst_no_bypass", rd_data_b[0], '0);
    drive();
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(a), AW'(a), AW'(a)};
      drive();
    end
    #2 chk("cnt_after_reset", XLEN'(busy_cnt_b), '0);

    wr_en = 2'b01; wr_addr[0] = 4'd3; wr_data[0] = 64'hDEADBEEF;
    drive();
    idle(); rd_addr = {4'd3, 4'd3, 4'd3};
    #2 chk("x3_port0", rd_data_n[0], 64'hDEADBEEF);
    chk("x3_port1", rd_data_n[1], 64'hDEADBEEF);
    drive();

    idle(); wr_en = 2'b01; wr_addr[0] = 4'd0; wr_data[0] = '1;
    #2 chk("x0_bypass", rd_data_b[0], '0);
    drive();
    idle();
    #2 chk("x0_stored", rd_data_n[0], '0);
    drive();

    wr_en = 2'b11; wr_addr = {4'd7, 4'd7}; wr_data = {64'h22, 64'h11}; rd_addr = {4'd7, 4'd7, 4'd7};
    #2 chk("x7_bypass_win", rd_data_b[0], 64'h22);
    chk("x7_nobypass_old", rd_data_n[0], '0);
    drive();
    idle(); rd_addr = {4'd7, 4'd7, 4'd7};
    #2 chk("x7_nobypass_new", rd_data_n[0], 64'h22);
    drive();

    idle(); rsv_en = 1'b1; rsv_addr = 4'd10;
    drive();
    rsv_addr = 4'd11;
    drive();
    idle(); rd_addr[0] = 4'd10;
    #2 chk("cnt_two_rsv", XLEN'(busy_cnt_b), 64'd2);
    chk("x10_busy", XLEN'(rd_busy_b[0]), 64'd1);
    drive();

    wr_en = 2'b01; wr_addr[0] = 4'd10; wr_data[0] = 64'd5; rd_addr[0] = 4'd10;
    #2 chk("x10_wb_busy_bypass", XLEN'(rd_busy_b[0]), 64'd0);
    chk("x10_wb_data_bypass", rd_data_b[0], 64'd5);
    chk("x10_wb_busy_stored", XLEN'(rd_busy_n[0]), 64'd1);
    drive();
    idle(); rd_addr[0] = 4'd10;
    #2 chk("cnt_after_wb", XLEN'(busy_cnt_b), 64'd1);
    chk("x10_data", rd_data_n[0], 64'd5);
    chk("x10_not_busy", XLEN'(rd_busy_n[0]), 64'd0);
    drive();

    idle(); rsv_en = 1'b1; rsv_addr = 4'd12;
    drive();
    wr_en = 2'b01; wr_addr[0] = 4'd12; wr_data[0] = 64'd9; rd_addr[0] = 4'd12;
    #2 chk("x12_rsv_wr_busy", XLEN'(rd_busy_b[0]), 64'd1);
    drive();
    idle(); rd_addr[0] = 4'd12;
    #2 chk("cnt_rsv_wr", XLEN'(busy_cnt_b), 64'd2);
    chk("x12_data", rd_data_n[0], 64'd9);
    chk("x12_still_busy", XLEN'(rd_busy_n[0]), 64'd1);
    drive();

    idle(); rsv_en = 1'b1; rsv_addr = 4'd0;
    drive();
    idle();
    #2 chk("cnt_rsv_x0", XLEN'(busy_cnt_b), 64'd2);
    chk("vec0_zero", XLEN'(busy_vec_b[0]), 64'd0);
    drive();

    idle(); wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 64'h1234;
    drive();
    rst_n = 1'b0; wr_data[0] = 64'h5678;
    drive();
    rst_n = 1'b1; idle(); rd_addr[0] = 4'd5;
    #2 chk("x5_after_reset", rd_data_n[0], '0);
    chk("cnt_after_midreset", XLEN'(busy_cnt_b), '0);
    drive();

    for (int n = 0; n < NRAND; n++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      wr_en    = NWR'($urandom);
      rsv_en   = 1'($urandom);
      rsv_addr = AW'($urandom);
      for (int p = 0; p < NWR; p++) begin
        wr_addr[p] = AW'($urandom);
        wr_data[p] = {$urandom, $urandom};
      end
      for (int i = 0; i < NRD; i++) begin
        rd_addr[i] = ($urandom_range(0, 1) == 1) ? wr_addr[$urandom_range(0, NWR-1)] : AW'($urandom);
      end
      drive();
    end

    idle();
    @(negedge clk); #1;
    chk("scoreboard_drained", XLEN'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
